// File: rtl/bpred_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
package bpred_pkg;

  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [1:0] RVC_Q1      = 2'b01;
  localparam logic [1:0] RVC_NONE    = 2'b11;
  // funct3[2:1] of C.BEQZ (110) and C.BNEZ (111)
  localparam logic [1:0] RVC_F3_BR   = 2'b11;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

endpackage

// File: rtl/bpred_if.sv
// Fetch lookup and execute-stage training signals of the branch predictor.
interface bpred_if;

  logic [63:0]        pc;
  logic [31:0]        ins;
  logic               ins_valid;
  logic               c_ins;
  logic               is_br;
  logic               pr_taken;
  logic signed [12:0] pr_offs;
  logic               br_upd;
  logic [63:0]        br_upd_pc;
  logic               br_upd_taken;

  modport master (
    output pc, ins, ins_valid, br_upd, br_upd_pc, br_upd_taken,
    input  c_ins, is_br, pr_taken, pr_offs
  );

  modport slave (
    input  pc, ins, ins_valid, br_upd, br_upd_pc, br_upd_taken,
    output c_ins, is_br, pr_taken, pr_offs
  );

endinterface

// File: rtl/bpred_dec.sv
// Combinational decode of conditional branches (B-type, C.BEQZ/C.BNEZ) and their offsets.
module bpred_dec
  import bpred_pkg::*;
(
  input  logic [31:0]        ins,
  input  logic               ins_valid,
  output logic               c_ins,
  output logic               is_br,
  output logic signed [12:0] pr_offs
);

  logic               b_type;
  logic               c_br;
  logic signed [12:0] offs_b;
  logic signed [12:0] offs_c;
  logic               unused_ins;

  assign c_ins  = (ins[1:0] != RVC_NONE);
  assign b_type = (ins[6:0] == OPC_BRANCH);
  assign c_br   = (ins[1:0] == RVC_Q1) && (ins[15:14] == RVC_F3_BR);
  assign is_br  = ins_valid & (b_type | c_br);

  assign offs_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign offs_c = {{4{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};

  always_comb begin
    pr_offs = '0;
    if (is_br) pr_offs = b_type ? offs_b : offs_c;
  end

  assign unused_ins = ^{ins[24:16], ins[13]};

endmodule

// File: rtl/bpred.sv
// Branch predictor: PC-indexed table of 2-bit saturating counters, read combinationally
// at fetch and trained by execute-stage resolution.
module bpred
  import bpred_pkg::*;
#(
  parameter int          BHT_IDX_W = 6,
  parameter logic [1:0]  CNT_RST   = 2'b01
) (
  input  logic   clk,
  input  logic   rst_n,
  bpred_if.slave bp
);

  localparam int BHT_N = 2 ** BHT_IDX_W;

  function automatic cnt_e cnt_sat(input cnt_e c, input logic taken);
    cnt_e n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

  cnt_e                 bht [BHT_N];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic                 is_br;
  logic                 unused_pc;

  bpred_dec u_dec (
    .ins       (bp.ins),
    .ins_valid (bp.ins_valid),
    .c_ins     (bp.c_ins),
    .is_br     (is_br),
    .pr_offs   (bp.pr_offs)
  );

  // Halfword-granular index so adjacent compressed branches get distinct counters
  assign rd_idx      = bp.pc[BHT_IDX_W:1];
  assign wr_idx      = bp.br_upd_pc[BHT_IDX_W:1];
  assign bp.is_br    = is_br;
  assign bp.pr_taken = is_br & bht[rd_idx][1];

  // Lookup reads the registered value, so a same-cycle update is seen next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= cnt_e'(CNT_RST);
    end else if (bp.br_upd) begin
      bht[wr_idx] <= cnt_sat(bht[wr_idx], bp.br_upd_taken);
    end
  end

  assign unused_pc = ^{bp.pc[63:BHT_IDX_W+1], bp.pc[0],
                       bp.br_upd_pc[63:BHT_IDX_W+1], bp.br_upd_pc[0]};

endmodule

// File: tb/tb_bpred.sv
// Randomized and directed bench for bpred against a behavioural counter-table model.
module tb_bpred;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  int   cnt [64];
  bit   armed = 1'b0;
  logic [12:0] offs_u;

  always #5 clk = ~clk;

  bpred_if bif ();

  bpred dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bif.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [63:0] p);
    return int'((p >> 1) % 64);
  endfunction

  function automatic bit m_btype(input logic [31:0] i);
    return i[6:0] == 7'h63;
  endfunction

  function automatic bit m_cbr(input logic [31:0] i);
    return (i[1:0] == 2'b01) && (i[15:14] == 2'b11);
  endfunction

  // Branch offset as a weighted sum of immediate fields
  function automatic logic [12:0] m_offs(input logic [31:0] i, input bit v);
    int imm;
    imm = 0;
    if (v && m_btype(i))
      imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    else if (v && m_cbr(i))
      imm = (i[12] ? -256 : 0) + int'(i[6:5]) * 64 + int'(i[2]) * 32 + int'(i[11:10]) * 8
            + int'(i[4:3]) * 2;
    return imm[12:0];
  endfunction

  task automatic drive(input logic r, input logic [63:0] p, input logic [31:0] i, input logic v,
                       input logic u, input logic [63:0] up, input logic ut);
    bit br;
    rst_n = r;
    bif.pc = p;
    bif.ins = i;
    bif.ins_valid = v;
    bif.br_upd = u;
    bif.br_upd_pc = up;
    bif.br_upd_taken = ut;
    #2;
    br = v && (m_btype(i) || m_cbr(i));
    offs_u = bif.pr_offs;
    check("c_ins", bif.c_ins, i[1:0] != 2'b11);
    check("is_br", bif.is_br, br);
    check("pr_offs", offs_u, m_offs(i, v));
    if (armed) check("pr_taken", bif.pr_taken, br && cnt[idx_of(p)] >= 2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) cnt[k] = 1;
      armed = 1'b1;
    end else if (bif.br_upd) begin
      if (bif.br_upd_taken) cnt[idx_of(bif.br_upd_pc)] = (cnt[idx_of(bif.br_upd_pc)] == 3) ? 3 : cnt[idx_of(bif.br_upd_pc)] + 1;
      else                  cnt[idx_of(bif.br_upd_pc)] = (cnt[idx_of(bif.br_upd_pc)] == 0) ? 0 : cnt[idx_of(bif.br_upd_pc)] - 1;
    end
    #1;
  endtask

  task automatic step(input logic r, input logic [63:0] p, input logic [31:0] i, input logic v,
                      input logic u, input logic [63:0] up, input logic ut);
    drive(r, p, i, v, u, up, ut);
    tick();
  endtask

  localparam logic [63:0] PC0 = 64'h8000_0000;
  localparam logic [63:0] PC2 = 64'h8000_0002;
  localparam logic [63:0] PCX = 64'h8000_0010;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;
  localparam logic [31:0] CBZ = 32'h0000_C111;
  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [63:0] p, up;
    logic [31:0] i;
    step(1'b0, PC0, NOP, 1'b0, 1'b0, PC0, 1'b0);
    step(1'b0, PC0, NOP, 1'b0, 1'b0, PC0, 1'b0);

    drive(1'b1, PC0, BEQ, 1'b1, 1'b0, PC0, 1'b0);
    check("rst_is_br", bif.is_br, 1'b1);
    check("rst_taken", bif.pr_taken, 1'b0);
    offs_u = bif.pr_offs;
    check("beq_offs", offs_u, 13'h1FFC);
    tick();

    step(1'b1, PC0, NOP, 1'b1, 1'b1, PC0, 1'b1);
    drive(1'b1, PC0, BEQ, 1'b1, 1'b0, PC0, 1'b0);
    check("train_01_10", bif.pr_taken, 1'b1);
    tick();
    step(1'b1, PC0, NOP, 1'b1, 1'b1, PC0, 1'b1);
    step(1'b1, PC0, NOP, 1'b1, 1'b1, PC0, 1'b1);
    step(1'b1, PC0, NOP, 1'b1, 1'b1, PC0, 1'b0);
    drive(1'b1, PC0, BEQ, 1'b1, 1'b0, PC0, 1'b0);
    check("sat_then_dec", bif.pr_taken, 1'b1);
    tick();

    drive(1'b1, PC2, CBZ, 1'b1, 1'b0, PC0, 1'b0);
    check("cbz_c_ins", bif.c_ins, 1'b1);
    check("cbz_is_br", bif.is_br, 1'b1);
    offs_u = bif.pr_offs;
    check("cbz_offs", offs_u, 13'h0004);
    tick();
    step(1'b1, PC2, NOP, 1'b1, 1'b1, PC2, 1'b1);
    step(1'b1, PC2, NOP, 1'b1, 1'b1, PC2, 1'b1);
    step(1'b1, PC0, BEQ, 1'b1, 1'b1, PC2, 1'b0);
    step(1'b1, PC0, BEQ, 1'b1, 1'b1, PC2, 1'b1);

    drive(1'b1, PCX, BEQ, 1'b1, 1'b1, PCX, 1'b1);
    check("rbw_same", bif.pr_taken, 1'b0);
    tick();
    drive(1'b1, PCX, BEQ, 1'b1, 1'b0, PCX, 1'b0);
    check("rbw_next", bif.pr_taken, 1'b1);
    tick();

    drive(1'b1, PC2, NOP, 1'b1, 1'b0, PC0, 1'b0);
    check("nop_is_br", bif.is_br, 1'b0);
    check("nop_taken", bif.pr_taken, 1'b0);
    offs_u = bif.pr_offs;
    check("nop_offs", offs_u, 13'h0);
    tick();
    drive(1'b1, PC2, BEQ, 1'b0, 1'b0, PC0, 1'b0);
    check("inv_taken", bif.pr_taken, 1'b0);
    tick();

    step(1'b0, PC2, BEQ, 1'b1, 1'b1, PC2, 1'b1);
    drive(1'b1, PC2, BEQ, 1'b1, 1'b0, PC0, 1'b0);
    check("rst_drop_upd", bif.pr_taken, 1'b0);
    tick();
    drive(1'b1, PC0, BEQ, 1'b1, 1'b0, PC0, 1'b0);
    check("rst_all", bif.pr_taken, 1'b0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      p  = PC0 + 64'(2 * $urandom_range(0, 7)) + 64'(128 * $urandom_range(0, 3));
      up = PC0 + 64'(2 * $urandom_range(0, 7)) + 64'(128 * $urandom_range(0, 3));
      i  = $urandom;
      case ($urandom_range(0, 3))
        0: i[6:0] = 7'h63;
        1: begin i[15:14] = 2'b11; i[1:0] = 2'b01; end
        2: ;
        default: i[1:0] = 2'($urandom_range(0, 2));
      endcase
      step(($urandom_range(0, 299) != 0), p, i, ($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
